// File: rtl/dictionary_loader_if.sv
// Handshake bundle for dictionary_loader: valid/ready source side plus dictionary write burst side.
// master = upstream source and dictionary, slave = loader.
interface dictionary_loader_if #(
  parameter int VAL_WIDTH = 7
);
  logic                 in_valid;
  logic                 in_ready;
  logic [VAL_WIDTH-1:0] in_val;
  logic                 write_enable;
  logic [VAL_WIDTH-1:0] write_val;

  modport master (
    output in_valid,
    output in_val,
    input  in_ready,
    input  write_enable,
    input  write_val
  );

  modport slave (
    input  in_valid,
    input  in_val,
    output in_ready,
    output write_enable,
    output write_val
  );
endinterface

// File: rtl/dictionary_loader.sv
// Collects 2**KEY_WIDTH values from a valid/ready source, then replays them as one gapless write burst.
// Optional duplicate detection is enabled by defining DICTIONARY_LOADER_DUP_CHECK_EN.
module dictionary_loader #(
  parameter int KEY_WIDTH = 3,
  parameter int VAL_WIDTH = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  dictionary_loader_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                dict_loaded,
  output logic                dup_err
);
  localparam int N = 2**KEY_WIDTH;

  typedef logic [KEY_WIDTH:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(N - 1);

  typedef enum logic [1:0] {IDLE, FILL, BURST, DONE} state_t;

  state_t               state;
  cnt_t                 fill_cnt;
  cnt_t                 burst_cnt;
  logic [VAL_WIDTH-1:0] val_buf [N];
  logic [KEY_WIDTH-1:0] burst_idx_nxt;
  logic                 xfer;
  logic                 dup_hit;

  assign xfer          = (state == FILL) && bus.in_valid && bus.in_ready;
  assign burst_idx_nxt = burst_cnt[KEY_WIDTH-1:0] + KEY_WIDTH'(1);

`ifdef DICTIONARY_LOADER_DUP_CHECK_EN
  always_comb begin
    dup_hit = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if ((cnt_t'(i) < fill_cnt) && (val_buf[i] == bus.in_val)) dup_hit = 1'b1;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  // Buffer has no reset; its contents are only read after a complete fill.
  always_ff @(posedge clk) begin
    if (xfer) val_buf[fill_cnt[KEY_WIDTH-1:0]] <= bus.in_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      fill_cnt         <= '0;
      burst_cnt        <= '0;
      bus.in_ready     <= 1'b0;
      bus.write_enable <= 1'b0;
      bus.write_val    <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      dict_loaded      <= 1'b0;
      dup_err          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= FILL;
            fill_cnt     <= '0;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            dict_loaded  <= 1'b0;
            dup_err      <= 1'b0;
          end
        end
        FILL: begin
          if (xfer) begin
            fill_cnt <= fill_cnt + cnt_t'(1);
            if (dup_hit) dup_err <= 1'b1;
            // Entry 0 is already stored, so burst cycle 0 can start on the edge of the last transfer.
            if (fill_cnt == LAST) begin
              state            <= BURST;
              bus.in_ready     <= 1'b0;
              burst_cnt        <= '0;
              bus.write_enable <= 1'b1;
              bus.write_val    <= val_buf[0];
            end
          end
        end
        BURST: begin
          if (burst_cnt == LAST) begin
            state            <= DONE;
            bus.write_enable <= 1'b0;
            bus.write_val    <= '0;
            busy             <= 1'b0;
            done             <= 1'b1;
            dict_loaded      <= 1'b1;
          end else begin
            burst_cnt     <= burst_cnt + cnt_t'(1);
            bus.write_val <= val_buf[burst_idx_nxt];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dictionary_loader.sv
// Scoreboard bench for dictionary_loader: driver queues expected burst values, monitor checks the burst.
// Honours DICTIONARY_LOADER_DUP_CHECK_EN for the expected dup_err behaviour.
module tb_dictionary_loader;
  localparam int KW = 3;
  localparam int VW = 7;
  localparam int N  = 2**KW;

`ifdef DICTIONARY_LOADER_DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  typedef logic [VW-1:0] vec_t [N];

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy, done, dict_loaded, dup_err;

  dictionary_loader_if #(.VAL_WIDTH(VW)) bus ();

  dictionary_loader #(.KEY_WIDTH(KW), .VAL_WIDTH(VW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus.slave),
    .busy        (busy),
    .done        (done),
    .dict_loaded (dict_loaded),
    .dup_err     (dup_err)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int          done_seen   = 0;
  logic [VW-1:0] exp_q [$];
  bit          mon_prev_we = 1'b0;
  int          mon_run_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every burst beat is popped from the scoreboard; runs must be N long and followed by done.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        mon_prev_we = 1'b0;
        mon_run_len = 0;
      end else begin
        if (bus.write_enable) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL burst_extra: write_val %0h with nothing expected at %0t", bus.write_val, $time);
          end else begin
            check("burst_val", bus.write_val, exp_q.pop_front());
          end
          mon_run_len++;
        end else if (mon_prev_we) begin
          check("burst_len", mon_run_len, N);
          check("done_after_burst", done, 1);
          mon_run_len = 0;
        end else if (done) begin
          vectors++;
          miscompares++;
          $display("FAIL done_spurious: done=1 expected 0 at %0t", $time);
        end
        if (done) done_seen++;
        mon_prev_we = bus.write_enable;
      end
    end
  end

  // One full load; gap_after/gap_len stall in_valid, poke_start pulses start in FILL and BURST,
  // reset_at >= 0 asserts reset on that burst cycle and abandons the load.
  task automatic load(input vec_t v, input int gap_after, input int gap_len,
                      input bit poke_start, input int reset_at);
    bit exp_dup = 1'b0;
    int seen0   = done_seen;
    int waited  = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("ready_after_start", bus.in_ready, 1);
    check("busy_after_start", busy, 1);
    check("loaded_clears", dict_loaded, 0);
    check("dup_clears", dup_err, 0);
    for (int k = 0; k < N; k++) begin
      bus.in_valid = 1'b1;
      bus.in_val   = v[k];
      if (poke_start && k == 2) start = 1'b1;
      check("ready_fill", bus.in_ready, 1);
      @(posedge clk); #1;
      start = 1'b0;
      exp_q.push_back(v[k]);
      for (int j = 0; j < k; j++) if (v[j] == v[k]) exp_dup = DUP_EN;
      check("dup_err", dup_err, exp_dup);
      if (k == gap_after && gap_len > 0) begin
        bus.in_valid = 1'b0;
        bus.in_val   = VW'($urandom);
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_val   = VW'($urandom);
    check("ready_after_fill", bus.in_ready, 0);
    check("we_first_beat", bus.write_enable, 1);
    if (reset_at >= 0) begin
      repeat (reset_at) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("rst_we", bus.write_enable, 0);
      check("rst_wval", bus.write_val, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_loaded", dict_loaded, 0);
      check("rst_ready", bus.in_ready, 0);
      check("rst_dup", dup_err, 0);
      @(posedge clk); #1 reset = 1'b0;
      return;
    end
    while (waited < N + 4 && !done) begin
      @(posedge clk); #1;
      waited++;
      start = (poke_start && waited == 2);
    end
    start = 1'b0;
    check("done_latency", waited, N);
    check("loaded_at_done", dict_loaded, 1);
    check("busy_at_done", busy, 0);
    check("dup_at_done", dup_err, exp_dup);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("loaded_holds", dict_loaded, 1);
    check("ready_in_done", bus.in_ready, 0);
    check("done_count", done_seen - seen0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_val   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", bus.in_ready, 0);
    check("reset_we", bus.write_enable, 0);
    check("reset_wval", bus.write_val, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_loaded", dict_loaded, 0);
    check("reset_dup", dup_err, 0);
    reset = 1'b0;

    for (int i = 0; i < N; i++) v[i] = VW'(10 + i);
    load(v, -1, 0, 1'b0, -1);
    load(v, 3, 3, 1'b0, -1);
    load(v, -1, 0, 1'b1, -1);
    load(v, -1, 0, 1'b0, 3);

    for (int i = 0; i < N; i++) v[i] = VW'($urandom);
    load(v, -1, 0, 1'b0, -1);

    v[0] = 7'h7F;
    v[1] = 7'h00;
    for (int i = 2; i < N; i++) v[i] = VW'($urandom);
    load(v, -1, 0, 1'b0, -1);

    for (int i = 0; i < N; i++) v[i] = VW'(i + 1);
    v[3] = 7'd2;
    for (int i = 4; i < N; i++) v[i] = VW'(i);
    load(v, -1, 0, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) v[i] = VW'($urandom_range(0, 15));
      load(v, int'($urandom_range(0, N - 2)), int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)), -1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
